// File: rtl/fft_ctrl_pkg.sv
// Shared types and width helpers for the FFT stage controller.
// State encoding plus functions that derive port widths from the size parameters.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int LOG2N_MIN  = 2;
  localparam int LOG2N_MAX  = 10;
  localparam int BF_LAT_MIN = 1;
  localparam int BF_LAT_MAX = 8;

  function automatic int stage_w(input int log2n);
    return $clog2(log2n);
  endfunction

  function automatic int idx_w(input int log2n);
    return log2n - 1;
  endfunction

  function automatic int cfg_w(input int log2n);
    return $clog2(log2n + 1);
  endfunction

  function automatic int cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/fft_stage_ctrl_if.sv
// Control/status bundle between the FFT stage controller and its surroundings.
// The controller takes the slave side; the sequencer or bench takes the master side.
interface fft_stage_ctrl_if #(
  parameter int LOG2N = 3
);
  import fft_ctrl_pkg::*;

  localparam int SW = stage_w(LOG2N);
  localparam int IW = idx_w(LOG2N);
  localparam int CW = cfg_w(LOG2N);

  logic          start;
  logic [CW-1:0] cfg_log2n;
  logic          abort;
  logic          out_ready;
  logic          ready;
  logic          busy;
  logic          cfg_err;
  logic [SW-1:0] stage;
  logic [IW-1:0] bf_idx;
  logic [IW-1:0] tw_addr;
  logic          bf_enable;
  logic          mux_sel;
  logic          reg_we;
  logic [IW-1:0] wr_idx;
  logic          done;
  logic          data_valid;

  modport master (
    output start, cfg_log2n, abort, out_ready,
    input  ready, busy, cfg_err, stage, bf_idx, tw_addr, bf_enable,
           mux_sel, reg_we, wr_idx, done, data_valid
  );

  modport slave (
    input  start, cfg_log2n, abort, out_ready,
    output ready, busy, cfg_err, stage, bf_idx, tw_addr, bf_enable,
           mux_sel, reg_we, wr_idx, done, data_valid
  );

endinterface

// File: rtl/fft_ctrl_delay.sv
// Fixed-depth delay line for the butterfly write strobe and index.
// A synchronous flush empties the line so no stale write escapes after an abort.
module fft_ctrl_delay
  import fft_ctrl_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         i_flush,
  input  logic         i_we,
  input  logic [W-1:0] i_idx,
  output logic         o_we,
  output logic [W-1:0] o_idx
);

  if (DEPTH < BF_LAT_MIN || DEPTH > BF_LAT_MAX) begin : g_bad_depth
    $error("fft_ctrl_delay: DEPTH out of range");
  end

  logic         r_we  [DEPTH];
  logic [W-1:0] r_idx [DEPTH];

  always_ff @(posedge clk) begin
    if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_we[i]  <= 1'b0;
        r_idx[i] <= '0;
      end
    end else begin
      r_we[0]  <= i_we;
      r_idx[0] <= i_idx;
      for (int i = 1; i < DEPTH; i++) begin
        r_we[i]  <= r_we[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  assign o_we  = r_we[DEPTH-1];
  assign o_idx = r_idx[DEPTH-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// Sequencer for an in-place radix-2 FFT: issues butterflies stage by stage,
// waits out the butterfly latency between stages and hands the result downstream.
module fft_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int LOG2N  = 3,
  parameter int BF_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  fft_stage_ctrl_if.slave bus
);

  localparam int SW = stage_w(LOG2N);
  localparam int IW = idx_w(LOG2N);
  localparam int CW = cfg_w(LOG2N);
  localparam int NW = cnt_w(BF_LAT);

  if (LOG2N < LOG2N_MIN || LOG2N > LOG2N_MAX) begin : g_bad_log2n
    $error("fft_stage_ctrl: LOG2N out of range");
  end
  if (BF_LAT < BF_LAT_MIN || BF_LAT > BF_LAT_MAX) begin : g_bad_lat
    $error("fft_stage_ctrl: BF_LAT out of range");
  end

  state_t        r_state, w_state_n;
  logic [SW-1:0] r_stage, w_stage_n;
  logic [IW-1:0] r_bf_idx, w_idx_n;
  logic [CW-1:0] r_L, w_L_n;
  logic [NW-1:0] r_cnt, w_cnt_n;
  logic          r_done, w_done_n;
  logic          r_cfg_err, w_cfg_err_n;

  int            w_cfg_lim;
  logic          w_cfg_ok;
  logic [IW-1:0] w_idx_max;
  logic          w_last_idx;
  logic          w_last_stage;
  logic          w_drain_end;
  logic          w_ready;
  logic          w_busy;
  logic          w_bf_en;
  logic [IW-1:0] w_tw;
  logic          w_flush;
  logic          w_wr_we;
  logic [IW-1:0] w_wr_idx;

  // Size is legal when 1 <= cfg_log2n <= LOG2N; signed headroom avoids a constant compare.
  assign w_cfg_lim = LOG2N - int'(bus.cfg_log2n);
  assign w_cfg_ok  = (bus.cfg_log2n != '0) && (w_cfg_lim >= 0);

  // Last butterfly of a stage is 2^(L-1)-1; for L=LOG2N this wraps to all ones.
  assign w_idx_max    = IW'((32'd1 << (32'(r_L) - 32'd1)) - 32'd1);
  assign w_last_idx   = (r_bf_idx == w_idx_max);
  assign w_last_stage = (32'(r_stage) == (32'(r_L) - 32'd1));
  assign w_drain_end  = (r_cnt == NW'(BF_LAT - 1));

  assign w_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_busy  = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_bf_en = (r_state == S_ISSUE);

  // Twiddle step doubles in resolution each stage: (idx mod 2^s) << (L-1-s).
  assign w_tw = IW'((32'(r_bf_idx) & ((32'd1 << r_stage) - 32'd1))
                    << (32'(r_L) - 32'd1 - 32'(r_stage)));

  always_comb begin
    w_state_n   = r_state;
    w_stage_n   = r_stage;
    w_idx_n     = r_bf_idx;
    w_L_n       = r_L;
    w_cnt_n     = r_cnt;
    w_done_n    = 1'b0;
    w_cfg_err_n = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_ready) begin
          w_state_n = S_IDLE;
          if (bus.start && w_cfg_ok) begin
            w_state_n = S_ISSUE;
            w_L_n     = bus.cfg_log2n;
            w_stage_n = '0;
            w_idx_n   = '0;
          end else if (bus.start) begin
            w_cfg_err_n = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (w_last_idx) begin
          w_state_n = S_DRAIN;
          w_cnt_n   = '0;
        end else begin
          w_idx_n = r_bf_idx + IW'(1);
        end
      end
      S_DRAIN: begin
        if (w_drain_end) begin
          if (w_last_stage) begin
            w_state_n = S_DONE;
            w_done_n  = 1'b1;
          end else begin
            w_state_n = S_ISSUE;
            w_stage_n = r_stage + SW'(1);
            w_idx_n   = '0;
          end
        end else begin
          w_cnt_n = r_cnt + NW'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // Abort outranks start and out_ready in every state.
    if (bus.abort) begin
      w_state_n   = S_IDLE;
      w_stage_n   = '0;
      w_idx_n     = '0;
      w_done_n    = 1'b0;
      w_cfg_err_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_stage   <= '0;
      r_bf_idx  <= '0;
      r_L       <= CW'(LOG2N);
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_stage   <= w_stage_n;
      r_bf_idx  <= w_idx_n;
      r_L       <= w_L_n;
      r_cnt     <= w_cnt_n;
      r_done    <= w_done_n;
      r_cfg_err <= w_cfg_err_n;
    end
  end

  // Results land BF_LAT cycles after issue; reset and abort both drop in-flight writes.
  assign w_flush = rst || bus.abort;

  fft_ctrl_delay #(
    .W     (IW),
    .DEPTH (BF_LAT)
  ) u_wr_delay (
    .clk     (clk),
    .i_flush (w_flush),
    .i_we    (w_bf_en),
    .i_idx   (r_bf_idx),
    .o_we    (w_wr_we),
    .o_idx   (w_wr_idx)
  );

  assign bus.ready      = w_ready;
  assign bus.busy       = w_busy;
  assign bus.cfg_err    = r_cfg_err;
  assign bus.stage      = r_stage;
  assign bus.bf_idx     = r_bf_idx;
  assign bus.tw_addr    = w_bf_en ? w_tw : '0;
  assign bus.bf_enable  = w_bf_en;
  assign bus.mux_sel    = (r_state == S_DONE) || (w_busy && (r_stage != '0));
  assign bus.reg_we     = w_wr_we;
  assign bus.wr_idx     = w_wr_idx;
  assign bus.done       = r_done;
  assign bus.data_valid = (r_state == S_DONE);

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: instance A (LOG2N=3, BF_LAT=1) and B (LOG2N=4, BF_LAT=3).
// Expected issue/write streams are queued at start and consumed by per-instance monitors.
module tb_fft_stage_ctrl;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    int stage;
    int idx;
    int tw;
    int mux;
  } iss_t;

  typedef struct {
    int idx;
    int cyc;
  } wr_t;

  typedef struct {
    int ready, busy, cfg_err, stage, bf_idx, tw_addr, bf_enable;
    int mux_sel, reg_we, wr_idx, done, data_valid;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt_a = 0;
  int   wr_cnt_b = 0;

  iss_t qa_iss[$];
  iss_t qb_iss[$];
  wr_t  qa_wr[$];
  wr_t  qb_wr[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_stage_ctrl_if #(.LOG2N(3)) if_a ();
  fft_stage_ctrl_if #(.LOG2N(4)) if_b ();

  fft_stage_ctrl #(.LOG2N(3), .BF_LAT(LAT_A)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  fft_stage_ctrl #(.LOG2N(4), .BF_LAT(LAT_B)) u_b (.clk(clk), .rst(rst), .bus(if_b));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t get(input int inst);
    obs_t o;
    if (inst == 0) begin
      o.ready = int'(if_a.ready);       o.busy = int'(if_a.busy);
      o.cfg_err = int'(if_a.cfg_err);   o.stage = int'(if_a.stage);
      o.bf_idx = int'(if_a.bf_idx);     o.tw_addr = int'(if_a.tw_addr);
      o.bf_enable = int'(if_a.bf_enable); o.mux_sel = int'(if_a.mux_sel);
      o.reg_we = int'(if_a.reg_we);     o.wr_idx = int'(if_a.wr_idx);
      o.done = int'(if_a.done);         o.data_valid = int'(if_a.data_valid);
    end else begin
      o.ready = int'(if_b.ready);       o.busy = int'(if_b.busy);
      o.cfg_err = int'(if_b.cfg_err);   o.stage = int'(if_b.stage);
      o.bf_idx = int'(if_b.bf_idx);     o.tw_addr = int'(if_b.tw_addr);
      o.bf_enable = int'(if_b.bf_enable); o.mux_sel = int'(if_b.mux_sel);
      o.reg_we = int'(if_b.reg_we);     o.wr_idx = int'(if_b.wr_idx);
      o.done = int'(if_b.done);         o.data_valid = int'(if_b.data_valid);
    end
    return o;
  endfunction

  // Whole transform of size 2^L: every stage issues idx 0..2^(L-1)-1.
  task automatic push_exp(input int inst, input int L);
    iss_t e;
    for (int s = 0; s < L; s++) begin
      for (int i = 0; i < (1 << (L - 1)); i++) begin
        e.stage = s;
        e.idx   = i;
        e.tw    = (i % (1 << s)) << (L - 1 - s);
        e.mux   = (s != 0) ? 1 : 0;
        if (inst == 0) qa_iss.push_back(e);
        else           qb_iss.push_back(e);
      end
    end
  endtask

  // Counts edges since acceptance until done; checks latency and the DONE-cycle outputs.
  task automatic wait_done(input int inst, input int exp_cyc, input string tag, input int already);
    int   n;
    obs_t o;
    n = already;
    o = get(inst);
    while (n < 400 && o.done != 1) begin
      step();
      n++;
      o = get(inst);
    end
    chk({tag, "_latency"}, n, exp_cyc);
    chk({tag, "_data_valid"}, o.data_valid, 1);
    chk({tag, "_mux_sel_done"}, o.mux_sel, 1);
    chk({tag, "_busy_done"}, o.busy, 0);
    chk({tag, "_bf_enable_done"}, o.bf_enable, 0);
  endtask

  always @(negedge clk) begin : mon_a
    iss_t e;
    wr_t  w;
    if (if_a.bf_enable) begin
      if (qa_iss.size() == 0) begin
        chk("A_issue_unexpected", int'(if_a.bf_enable), 0);
      end else begin
        e = qa_iss.pop_front();
        chk("A_stage", int'(if_a.stage), e.stage);
        chk("A_bf_idx", int'(if_a.bf_idx), e.idx);
        chk("A_tw_addr", int'(if_a.tw_addr), e.tw);
        chk("A_mux_sel", int'(if_a.mux_sel), e.mux);
        w.idx = e.idx;
        w.cyc = cyc + LAT_A;
        qa_wr.push_back(w);
      end
    end
    if (if_a.reg_we) begin
      wr_cnt_a++;
      if (qa_wr.size() == 0) begin
        chk("A_write_unexpected", int'(if_a.reg_we), 0);
      end else begin
        w = qa_wr.pop_front();
        chk("A_wr_idx", int'(if_a.wr_idx), w.idx);
        chk("A_wr_cycle", cyc, w.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    iss_t e;
    wr_t  w;
    if (if_b.bf_enable) begin
      if (qb_iss.size() == 0) begin
        chk("B_issue_unexpected", int'(if_b.bf_enable), 0);
      end else begin
        e = qb_iss.pop_front();
        chk("B_stage", int'(if_b.stage), e.stage);
        chk("B_bf_idx", int'(if_b.bf_idx), e.idx);
        chk("B_tw_addr", int'(if_b.tw_addr), e.tw);
        chk("B_mux_sel", int'(if_b.mux_sel), e.mux);
        w.idx = e.idx;
        w.cyc = cyc + LAT_B;
        qb_wr.push_back(w);
      end
    end
    if (if_b.reg_we) begin
      wr_cnt_b++;
      if (qb_wr.size() == 0) begin
        chk("B_write_unexpected", int'(if_b.reg_we), 0);
      end else begin
        w = qb_wr.pop_front();
        chk("B_wr_idx", int'(if_b.wr_idx), w.idx);
        chk("B_wr_cycle", cyc, w.cyc);
      end
    end
  end

  initial begin
    obs_t o;
    int   base;
    int   n;
    int   dn;

    rst = 1'b1;
    if_a.start = 1'b0; if_a.cfg_log2n = '0; if_a.abort = 1'b0; if_a.out_ready = 1'b0;
    if_b.start = 1'b0; if_b.cfg_log2n = '0; if_b.abort = 1'b0; if_b.out_ready = 1'b0;
    repeat (3) step();

    // Reset state
    o = get(0);
    chk("rst_ready", o.ready, 1);           chk("rst_busy", o.busy, 0);
    chk("rst_cfg_err", o.cfg_err, 0);       chk("rst_stage", o.stage, 0);
    chk("rst_bf_idx", o.bf_idx, 0);         chk("rst_tw_addr", o.tw_addr, 0);
    chk("rst_bf_enable", o.bf_enable, 0);   chk("rst_mux_sel", o.mux_sel, 0);
    chk("rst_reg_we", o.reg_we, 0);         chk("rst_wr_idx", o.wr_idx, 0);
    chk("rst_done", o.done, 0);             chk("rst_data_valid", o.data_valid, 0);
    o = get(1);
    chk("rstB_ready", o.ready, 1);          chk("rstB_busy", o.busy, 0);
    rst = 1'b0;
    step();

    // Size 8 on A; start held 3 extra cycles while busy must be ignored
    if_a.out_ready = 1'b1;
    base = wr_cnt_a;
    if_a.cfg_log2n = 2'd3;
    if_a.start = 1'b1;
    push_exp(0, 3);
    step();
    repeat (3) step();
    if_a.start = 1'b0;
    wait_done(0, 15, "A_n8", 3);
    chk("A_n8_ready_done", get(0).ready, 1);
    chk("A_n8_writes", wr_cnt_a - base, 12);
    step();
    o = get(0);
    chk("A_n8_done_pulse", o.done, 0);
    chk("A_n8_idle_dv", o.data_valid, 0);
    chk("A_n8_idle_ready", o.ready, 1);

    // Size 4 with BF_LAT=3 on B
    if_b.out_ready = 1'b1;
    base = wr_cnt_b;
    if_b.cfg_log2n = 3'd2;
    if_b.start = 1'b1;
    push_exp(1, 2);
    step();
    if_b.start = 1'b0;
    wait_done(1, 10, "B_n4", 0);
    chk("B_n4_writes", wr_cnt_b - base, 4);
    step();

    // Illegal sizes: 0 on A; above LOG2N on B, whose 3-bit port can carry 5
    if_a.cfg_log2n = 2'd0;
    if_a.start = 1'b1;
    step();
    if_a.start = 1'b0;
    o = get(0);
    chk("A_cfg0_err", o.cfg_err, 1);
    chk("A_cfg0_busy", o.busy, 0);
    chk("A_cfg0_ready", o.ready, 1);
    step();
    o = get(0);
    chk("A_cfg0_err_pulse", o.cfg_err, 0);
    chk("A_cfg0_bf_en", o.bf_enable, 0);
    if_b.cfg_log2n = 3'd5;
    if_b.start = 1'b1;
    step();
    if_b.start = 1'b0;
    o = get(1);
    chk("B_cfg5_err", o.cfg_err, 1);
    chk("B_cfg5_busy", o.busy, 0);
    step();
    o = get(1);
    chk("B_cfg5_err_pulse", o.cfg_err, 0);
    chk("B_cfg5_bf_en", o.bf_enable, 0);
    repeat (3) step();

    // Abort at stage 1, bf_idx 2
    if_a.cfg_log2n = 2'd3;
    if_a.start = 1'b1;
    push_exp(0, 3);
    step();
    if_a.start = 1'b0;
    n = 0;
    while (n < 100 && !(if_a.bf_enable && if_a.stage == 2'd1 && if_a.bf_idx == 2'd2)) begin
      step();
      n++;
    end
    chk("A_abort_point", n, 7);
    if_a.abort = 1'b1;
    step();
    qa_iss.delete();
    qa_wr.delete();
    if_a.abort = 1'b0;
    o = get(0);
    chk("A_abort_ready", o.ready, 1);
    chk("A_abort_busy", o.busy, 0);
    chk("A_abort_bf_en", o.bf_enable, 0);
    chk("A_abort_reg_we", o.reg_we, 0);
    base = wr_cnt_a;
    dn = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      dn += int'(if_a.done) + int'(if_a.data_valid);
    end
    chk("A_abort_no_done", dn, 0);
    chk("A_abort_no_writes", wr_cnt_a - base, 0);
    base = wr_cnt_a;
    if_a.start = 1'b1;
    push_exp(0, 3);
    step();
    if_a.start = 1'b0;
    wait_done(0, 15, "A_restart", 0);
    chk("A_restart_writes", wr_cnt_a - base, 12);
    step();

    // Back-pressure in DONE, then back-to-back start with out_ready
    if_a.out_ready = 1'b0;
    if_a.cfg_log2n = 2'd2;
    if_a.start = 1'b1;
    push_exp(0, 2);
    step();
    if_a.start = 1'b0;
    wait_done(0, 6, "A_bp", 0);
    chk("A_bp_ready_low", get(0).ready, 0);
    if_a.cfg_log2n = 2'd3;
    if_a.start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      o = get(0);
      chk("A_bp_hold_dv", o.data_valid, 1);
      chk("A_bp_hold_done", o.done, 0);
      chk("A_bp_hold_ready", o.ready, 0);
      chk("A_bp_hold_bf_en", o.bf_enable, 0);
    end
    if_a.out_ready = 1'b1;
    #1;
    chk("A_b2b_ready", get(0).ready, 1);
    push_exp(0, 3);
    step();
    if_a.start = 1'b0;
    o = get(0);
    chk("A_b2b_bf_en", o.bf_enable, 1);
    chk("A_b2b_busy", o.busy, 1);
    chk("A_b2b_dv", o.data_valid, 0);
    wait_done(0, 15, "A_b2b", 0);
    step();

    // Reset mid-transform, with start also asserted
    if_a.start = 1'b1;
    push_exp(0, 3);
    step();
    if_a.start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    if_a.start = 1'b1;
    step();
    qa_iss.delete();
    qa_wr.delete();
    rst = 1'b0;
    if_a.start = 1'b0;
    o = get(0);
    chk("A_rst_mid_ready", o.ready, 1);
    chk("A_rst_mid_busy", o.busy, 0);
    chk("A_rst_mid_reg_we", o.reg_we, 0);
    chk("A_rst_mid_stage", o.stage, 0);
    chk("A_rst_mid_bf_idx", o.bf_idx, 0);
    base = wr_cnt_a;
    repeat (5) step();
    chk("A_rst_mid_no_writes", wr_cnt_a - base, 0);

    chk("A_queue_left", qa_iss.size() + qa_wr.size(), 0);
    chk("B_queue_left", qb_iss.size() + qb_wr.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
